spi_req_scheduler: RTL and testbench

Shares one `SPI_core` master between `P_NUM_REQ` requesters. Each requester hands over one data word through a valid/ready handshake. The scheduler buffers one word per requester, picks the next transaction round-robin, starts the core, and waits for completion. It then enforces an idle gap so the chip-select deasserts between frames. The block sits between the user-side sources (button/debounce logic, register writers) and `SPI_core` in the top level.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rr_arbiter.sv | 33 +++
 rtl/spi_req_scheduler.sv | 147 ++++++++++++++
 tb/tb_spi_req_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: scheduler state encoding and default frame parameters
// used by both the request scheduler and SPI_core.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } sched_state_t;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_NUM_REQ    = 2;
  localparam int SPI_GAP_CYCLES = 4;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or after rr_ptr,
// wrapping modulo P_NUM_REQ (which need not be a power of two).
module spi_rr_arbiter #(
  parameter int P_NUM_REQ = 2
) (
  input  logic [P_NUM_REQ-1:0]         pend,
  input  logic [$clog2(P_NUM_REQ)-1:0] rr_ptr,
  output logic [P_NUM_REQ-1:0]         winner,
  output logic                         valid
);

  localparam int PTR_W = $clog2(P_NUM_REQ);

  int               idx;
  logic [PTR_W-1:0] sel;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= P_NUM_REQ) idx = idx - P_NUM_REQ;
      sel = PTR_W'(idx);
      if (!valid && pend[sel]) begin
        winner[sel] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_scheduler.sv
// Shares one SPI_core between P_NUM_REQ requesters: one holding slot each,
// round-robin selection, start/done handshake with the core, then an idle gap.
//
// state  | meaning
// IDLE   | no frame in flight; launch when a slot is pending and the core is free
// LAUNCH | spi_start high for this single cycle
// WAIT   | frame shifting; spi_done releases the owner's slot
// GAP    | chip-select idle time, down-counter to zero
module spi_req_scheduler
  import spi_pkg::*;
#(
  parameter int P_DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int P_NUM_REQ    = SPI_NUM_REQ,
  parameter int P_GAP_CYCLES = SPI_GAP_CYCLES
) (
  input  logic                              clk_100,
  input  logic                              a_rst_n,
  input  logic                              s_rst,
  input  logic [P_NUM_REQ-1:0]              req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data,
  output logic [P_NUM_REQ-1:0]              req_ready,
  output logic [P_NUM_REQ-1:0]              req_done,
  output logic [P_NUM_REQ-1:0]              grant,
  output logic                              busy,
  output logic                              spi_start,
  output logic [P_DATA_WIDTH-1:0]           spi_data,
  input  logic                              spi_busy,
  input  logic                              spi_done
);

  localparam int PTR_W = $clog2(P_NUM_REQ);
  localparam int CNT_W = (P_GAP_CYCLES > 0) ? $clog2(P_GAP_CYCLES + 1) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(P_NUM_REQ - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (P_GAP_CYCLES > 0) ? CNT_W'(P_GAP_CYCLES - 1) : '0;

  sched_state_t           state;
  logic [P_NUM_REQ-1:0]   pend;
  logic [P_DATA_WIDTH-1:0] slot [P_NUM_REQ];
  logic [PTR_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       gap_cnt;

  logic [P_NUM_REQ-1:0]    win_oh;
  logic                    win_valid;
  logic [PTR_W-1:0]        win_idx;
  logic [P_DATA_WIDTH-1:0] win_data;
  logic                    done_hit;

  spi_rr_arbiter #(.P_NUM_REQ(P_NUM_REQ)) u_arb (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .winner (win_oh),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = PTR_W'(i);
        win_data = slot[i];
      end
    end
  end

  assign req_ready = ~pend;
  assign done_hit  = (state == WAIT) && spi_done;

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
      req_done  <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      spi_start <= 1'b0;
      spi_data  <= '0;
      for (int i = 0; i < P_NUM_REQ; i++) slot[i] <= '0;
    end else if (s_rst) begin
      state     <= IDLE;
      pend      <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
      req_done  <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      spi_start <= 1'b0;
      spi_data  <= '0;
      for (int i = 0; i < P_NUM_REQ; i++) slot[i] <= '0;
    end else begin
      req_done  <= '0;
      spi_start <= 1'b0;

      // The owner's slot is full, so a release and a new accept never hit the same bit.
      for (int i = 0; i < P_NUM_REQ; i++) begin
        if (done_hit && grant[i]) begin
          pend[i] <= 1'b0;
        end else if (req_valid[i] && !pend[i]) begin
          pend[i] <= 1'b1;
          slot[i] <= req_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
      end

      case (state)
        IDLE: begin
          if (win_valid && !spi_busy) begin
            state     <= LAUNCH;
            busy      <= 1'b1;
            grant     <= win_oh;
            spi_data  <= win_data;
            spi_start <= 1'b1;
            rr_ptr    <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (spi_done) begin
            req_done <= grant;
            grant    <= '0;
            if (P_GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_scheduler.sv
// Directed bench for spi_req_scheduler: default instance (gap 4) plus a zero-gap
// instance; the bench plays the SPI core by driving spi_busy / spi_done.
module tb_spi_req_scheduler;

  localparam int W = 8;
  localparam int N = 2;
  localparam int G = 4;

  logic           clk_100 = 1'b0;
  logic           a_rst_n;
  logic           s_rst;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready, req_done, grant;
  logic           busy, spi_start, spi_busy, spi_done;
  logic [W-1:0]   spi_data;

  logic [N-1:0]   z_valid;
  logic [N*W-1:0] z_data;
  logic [N-1:0]   z_ready, z_req_done, z_grant;
  logic           z_sched_busy, z_start, z_busy, z_done;
  logic [W-1:0]   z_spi_data;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int z_start_cnt = 0;

  always #5 clk_100 = ~clk_100;

  spi_req_scheduler #(.P_DATA_WIDTH(W), .P_NUM_REQ(N), .P_GAP_CYCLES(G)) dut (
    .clk_100(clk_100), .a_rst_n(a_rst_n), .s_rst(s_rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .req_done(req_done), .grant(grant), .busy(busy),
    .spi_start(spi_start), .spi_data(spi_data),
    .spi_busy(spi_busy), .spi_done(spi_done)
  );

  spi_req_scheduler #(.P_DATA_WIDTH(W), .P_NUM_REQ(N), .P_GAP_CYCLES(0)) dut_z (
    .clk_100(clk_100), .a_rst_n(a_rst_n), .s_rst(s_rst),
    .req_valid(z_valid), .req_data(z_data), .req_ready(z_ready),
    .req_done(z_req_done), .grant(z_grant), .busy(z_sched_busy),
    .spi_start(z_start), .spi_data(z_spi_data),
    .spi_busy(z_busy), .spi_done(z_done)
  );

  always @(posedge clk_100) begin
    if (spi_start) start_cnt++;
    if (|req_done) done_cnt++;
    if (z_start) z_start_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (spi_start !== 1'b1 && n < 40);
  endtask

  task automatic wait_zstart(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (z_start !== 1'b1 && n < 40);
  endtask

  // From LAUNCH: move into WAIT, pulse done, check the owner's release, wait for idle.
  task automatic finish_frame(input string tag, input logic [N-1:0] owner);
    int n;
    tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    check_val({tag, "_req_done"}, req_done, owner);
    check_val({tag, "_ready"}, req_ready & owner, owner);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check_val({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int snap_start, snap_done, snap_z;
    logic [N-1:0] seen_done;

    a_rst_n = 1'b0; s_rst = 1'b0;
    req_valid = '0; req_data = '0; spi_busy = 1'b0; spi_done = 1'b0;
    z_valid = '0; z_data = '0; z_busy = 1'b0; z_done = 1'b0;
    tick(); tick();
    check_val("rst_ready", req_ready, 2'b11);
    check_val("rst_done", req_done, 2'b00);
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_start", spi_start, 1'b0);
    check_val("rst_data", spi_data, 8'h00);
    a_rst_n = 1'b1;
    tick();

    // single request
    req_valid = 2'b01; req_data = 16'h00A5;
    tick();
    req_valid = '0;
    check_val("single_ready", req_ready, 2'b10);
    check_val("single_nostart", spi_start, 1'b0);
    tick();
    check_val("single_start", spi_start, 1'b1);
    check_val("single_data", spi_data, 8'hA5);
    check_val("single_grant", grant, 2'b01);
    check_val("single_busy", busy, 1'b1);
    tick();
    check_val("single_strobe", spi_start, 1'b0);
    tick(); tick();
    check_val("single_hold", spi_data, 8'hA5);
    check_val("single_wait_done", req_done, 2'b00);
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    check_val("single_req_done", req_done, 2'b01);
    check_val("single_ready_back", req_ready, 2'b11);
    check_val("single_grant_clr", grant, 2'b00);
    check_val("single_gap_busy", busy, 1'b1);
    tick();
    check_val("single_done_pulse", req_done, 2'b00);
    tick(); tick(); tick();
    check_val("single_gap_exit", busy, 1'b0);

    // simultaneous requests from a fresh pointer
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    req_valid = 2'b11; req_data = 16'h2211;
    tick();
    req_valid = '0;
    tick();
    check_val("simul_start0", spi_start, 1'b1);
    check_val("simul_data0", spi_data, 8'h11);
    check_val("simul_grant0", grant, 2'b01);
    tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    seen_done = req_done;
    check_val("simul_done0", seen_done, 2'b01);
    n = 1;
    while (spi_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    // counted from the cycle spi_done was high
    check_val("simul_gap_latency", n, G + 2);
    check_val("simul_data1", spi_data, 8'h22);
    check_val("simul_grant1", grant, 2'b10);
    finish_frame("simul_f1", 2'b10);

    // fairness: both held valid
    req_valid = 2'b11; req_data = 16'h2211;
    for (int k = 0; k < 6; k++) begin
      wait_start(n);
      check_val($sformatf("fair_start%0d", k), spi_start, 1'b1);
      check_val($sformatf("fair_grant%0d", k), grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      check_val($sformatf("fair_data%0d", k), spi_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      if (k == 5) req_valid = '0;
    end

    // asynchronous reset during WAIT (req0 still pending from the fairness run)
    wait_start(n);
    check_val("arst_pre_grant", grant, 2'b01);
    tick();
    a_rst_n = 1'b0;
    #1;
    check_val("arst_grant", grant, 2'b00);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_data", spi_data, 8'h00);
    check_val("arst_ready", req_ready, 2'b11);
    check_val("arst_start", spi_start, 1'b0);
    snap_start = start_cnt; snap_done = done_cnt;
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    a_rst_n = 1'b1;
    repeat (8) tick();
    check_val("arst_no_done", done_cnt, snap_done);
    check_val("arst_no_restart", start_cnt, snap_start);

    // synchronous clear during WAIT
    req_valid = 2'b10; req_data = 16'h5C00;
    tick();
    req_valid = '0;
    wait_start(n);
    check_val("srst_launch_lat", n, 1);
    check_val("srst_pre_grant", grant, 2'b10);
    tick();
    s_rst = 1'b1;
    #1;
    check_val("srst_not_yet", grant, 2'b10);
    tick();
    s_rst = 1'b0;
    check_val("srst_grant", grant, 2'b00);
    check_val("srst_busy", busy, 1'b0);
    check_val("srst_data", spi_data, 8'h00);
    check_val("srst_ready", req_ready, 2'b11);
    snap_start = start_cnt; snap_done = done_cnt;
    repeat (8) tick();
    check_val("srst_no_done", done_cnt, snap_done);
    check_val("srst_no_restart", start_cnt, snap_start);

    // core busy with an external owner
    spi_busy = 1'b1;
    req_valid = 2'b10; req_data = 16'h3C00;
    tick();
    req_valid = '0;
    snap_start = start_cnt;
    repeat (5) tick();
    check_val("cbusy_no_start", start_cnt, snap_start);
    check_val("cbusy_pending", req_ready, 2'b01);
    check_val("cbusy_idle", busy, 1'b0);
    spi_busy = 1'b0;
    wait_start(n);
    check_val("cbusy_release_lat", n, 1);
    check_val("cbusy_data", spi_data, 8'h3C);
    check_val("cbusy_grant", grant, 2'b10);
    finish_frame("cbusy_f", 2'b10);

    // zero-gap instance: back-to-back frames and a stray done
    z_valid = 2'b11; z_data = 16'h4433;
    tick();
    z_valid = '0;
    wait_zstart(n);
    check_val("zgap_data0", z_spi_data, 8'h33);
    tick();
    z_done = 1'b1;
    tick();
    z_done = 1'b0;
    check_val("zgap_done0", z_req_done, 2'b01);
    n = 1;
    while (z_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("zgap_latency", n, 2);
    check_val("zgap_data1", z_spi_data, 8'h44);
    check_val("zgap_grant1", z_grant, 2'b10);
    tick();
    z_done = 1'b1;
    tick();
    z_done = 1'b0;
    check_val("zgap_done1", z_req_done, 2'b10);
    check_val("zgap_idle", z_sched_busy, 1'b0);
    tick();
    snap_z = z_start_cnt;
    z_done = 1'b1;
    tick();
    z_done = 1'b0;
    tick();
    check_val("stray_done", z_req_done, 2'b00);
    check_val("stray_grant", z_grant, 2'b00);
    check_val("stray_busy", z_sched_busy, 1'b0);
    check_val("stray_data", z_spi_data, 8'h44);
    check_val("stray_ready", z_ready, 2'b11);
    check_val("stray_no_start", z_start_cnt, snap_z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
